// File: rtl/sprite_plot_arbiter.sv
// Round-robin owner of the single VGA plot port. Grants one sprite requester,
// latches its 5x5 description, walks the 25 locations row-major and pulses
// done[owner] when the sprite is finished.
module sprite_plot_arbiter #(
  parameter int N_REQ = 4,
  parameter int SCR_W = 160,
  parameter int SCR_H = 120
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     erase_in,
  input  logic [8*N_REQ-1:0]   x_base,
  input  logic [7*N_REQ-1:0]   y_base,
  input  logic [3*N_REQ-1:0]   col_in,
  input  logic [25*N_REQ-1:0]  shape_in,
  output logic                 plot_en,
  output logic [7:0]           x,
  output logic [6:0]           y,
  output logic [2:0]           colour,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     done,
  output logic                 busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LATCH = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Screen limits widened by one bit so a limit of 256/128 still compares.
  localparam logic [8:0] X_LIM = 9'(SCR_W);
  localparam logic [7:0] Y_LIM = 8'(SCR_H);

  logic [1:0]       state;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    owner;
  logic [PW-1:0]    win;
  logic             found;
  int               j;
  logic [4:0]       loc;
  logic [2:0]       col_c;
  logic [2:0]       row_c;
  logic [N_REQ-1:0] owner_oh;

  logic [7:0]       xb_l;
  logic [6:0]       yb_l;
  logic [2:0]       col_l;
  logic [24:0]      shape_l;
  logic             erase_l;

  logic [7:0]       px;
  logic [6:0]       py;
  logic             in_screen;

  // Round-robin search: first asserted req at or after ptr, wrapping.
  always_comb begin
    win   = ptr;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && req[PW'(j)]) begin
        found = 1'b1;
        win   = PW'(j);
      end
    end
  end

  // Pixel address for the current location; col_c/row_c track loc%5 and loc/5.
  always_comb begin
    owner_oh  = {{(N_REQ-1){1'b0}}, 1'b1} << owner;
    px        = xb_l + {5'b0, col_c};
    py        = yb_l + {4'b0, row_c};
    in_screen = ({1'b0, px} < X_LIM) && ({1'b0, py} < Y_LIM);
    gnt       = (state != S_IDLE) ? owner_oh : '0;
    done      = (state == S_DONE) ? owner_oh : '0;
    busy      = (state != S_IDLE);
  end

  // Control FSM: arbitration, location stepping and pointer advance.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      ptr   <= '0;
      owner <= '0;
      loc   <= '0;
      col_c <= '0;
      row_c <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req) begin
            owner <= win;
            state <= S_LATCH;
          end
        end
        S_LATCH: begin
          loc   <= '0;
          col_c <= '0;
          row_c <= '0;
          state <= S_DRAW;
        end
        S_DRAW: begin
          if (loc == 5'd24) begin
            state <= S_DONE;
          end else begin
            loc <= loc + 5'd1;
            if (col_c == 3'd4) begin
              col_c <= '0;
              row_c <= row_c + 3'd1;
            end else begin
              col_c <= col_c + 3'd1;
            end
          end
        end
        default: begin
          ptr   <= (owner == PW'(N_REQ-1)) ? '0 : owner + PW'(1);
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Snapshot the owner's sprite; inputs are ignored for the rest of the sprite.
  always_ff @(posedge clock) begin
    if (state == S_LATCH) begin
      xb_l    <= x_base[8*owner +: 8];
      yb_l    <= y_base[7*owner +: 7];
      col_l   <= col_in[3*owner +: 3];
      shape_l <= shape_in[25*owner +: 25];
      erase_l <= erase_in[owner];
    end
  end

  // Registered plot port: location k is presented the cycle after DRAW loc==k.
  always_ff @(posedge clock) begin
    if (reset) begin
      plot_en <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
    end else if (state == S_DRAW) begin
      plot_en <= in_screen && (erase_l || shape_l[loc]);
      x       <= px;
      y       <= py;
      colour  <= erase_l ? 3'b000 : col_l;
    end else begin
      plot_en <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sprite_plot_arbiter.sv
// Bench for sprite_plot_arbiter: directed sprite table, hand sequences for
// round-robin order / reset mid-draw / mid-draw input changes, then random
// traffic, all checked cycle by cycle against a transaction-level model.
module tb_sprite_plot_arbiter;

  localparam int N  = 4;
  localparam int SW = 160;
  localparam int SH = 120;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [N-1:0]   erase_in;
  logic [8*N-1:0] x_base;
  logic [7*N-1:0] y_base;
  logic [3*N-1:0] col_in;
  logic [25*N-1:0] shape_in;
  logic           plot_en;
  logic [7:0]     x;
  logic [6:0]     y;
  logic [2:0]     colour;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic           busy;

  sprite_plot_arbiter #(.N_REQ(N), .SCR_W(SW), .SCR_H(SH)) dut (
    .clock(clock), .reset(reset), .req(req), .erase_in(erase_in),
    .x_base(x_base), .y_base(y_base), .col_in(col_in), .shape_in(shape_in),
    .plot_en(plot_en), .x(x), .y(y), .colour(colour),
    .gnt(gnt), .done(done), .busy(busy)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Model: phase counts cycles since the IDLE cycle that accepted a request
  // (0 = idle, 1 = latch, 27 = done). Pixels are precomputed at the latch.
  int   m_phase = 0;
  int   m_owner = 0;
  int   m_ptr   = 0;
  logic m_en [25];
  int   m_x  [25];
  int   m_y  [25];
  int   m_c;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    logic            rs;
    logic [N-1:0]    rq;
    logic [N-1:0]    er;
    logic [8*N-1:0]  xbv;
    logic [7*N-1:0]  ybv;
    logic [3*N-1:0]  cv;
    logic [25*N-1:0] sv;
    logic [24:0]     shp;
    logic            eb;
    int xb, yb, xx, yy;
    logic e_en;
    rs = reset; rq = req; er = erase_in; xbv = x_base; ybv = y_base;
    cv = col_in; sv = shape_in;
    @(posedge clock);
    if (rs) begin
      m_phase = 0;
      m_ptr   = 0;
    end else if (m_phase == 0) begin
      if (rq != '0) begin
        for (int i = N-1; i >= 0; i--)
          if (rq[(m_ptr + i) % N]) m_owner = (m_ptr + i) % N;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      xb  = int'(xbv[8*m_owner +: 8]);
      yb  = int'(ybv[7*m_owner +: 7]);
      shp = sv[25*m_owner +: 25];
      eb  = er[m_owner];
      m_c = eb ? 0 : int'(cv[3*m_owner +: 3]);
      for (int k = 0; k < 25; k++) begin
        xx = (xb + k % 5) % 256;
        yy = (yb + k / 5) % 128;
        m_x[k]  = xx;
        m_y[k]  = yy;
        m_en[k] = (xx < SW) && (yy < SH) && (eb || shp[k]);
      end
      m_phase = 2;
    end else if (m_phase < 27) begin
      m_phase++;
    end else begin
      m_ptr   = (m_owner + 1) % N;
      m_phase = 0;
    end
    #1;
    chk("busy", busy, m_phase != 0);
    chk("gnt",  gnt,  (m_phase != 0) ? (1 << m_owner) : 0);
    chk("done", done, (m_phase == 27) ? (1 << m_owner) : 0);
    e_en = (m_phase >= 3) ? m_en[m_phase-3] : 1'b0;
    chk("plot_en", plot_en, e_en);
    if (e_en) begin
      chk("x", x, m_x[m_phase-3]);
      chk("y", y, m_y[m_phase-3]);
      chk("colour", colour, m_c);
    end
  endtask

  typedef struct {
    int          idx;
    logic        er;
    logic [7:0]  xb;
    logic [6:0]  yb;
    logic [2:0]  col;
    logic [24:0] shp;
    int          n_plot;
    int          fx, fy, lx, ly;
    int          ecol;
  } vec_t;

  vec_t tbl [6];

  // One sprite from a single requester; returns what the plot port showed.
  task automatic run_sprite(input int idx, output int cnt, output int fx, output int fy,
                            output int lx, output int ly, output int bad_col_vs,
                            input int ecol, output int done_at, input int chg_at);
    cnt = 0; fx = -1; fy = -1; lx = -1; ly = -1; bad_col_vs = 0; done_at = -1;
    req = '0;
    req[idx] = 1'b1;
    for (int c = 0; c < 28; c++) begin
      step();
      if (plot_en) begin
        cnt++;
        if (cnt == 1) begin fx = int'(x); fy = int'(y); end
        lx = int'(x); ly = int'(y);
        if (int'(colour) != ecol) bad_col_vs++;
      end
      if (done[idx]) begin
        done_at = c;
        req = '0;
      end
      if (c == chg_at) begin
        x_base[8*idx +: 8]    = 8'd100;
        shape_in[25*idx +: 25] = '0;
        col_in[3*idx +: 3]    = 3'd1;
        req = '0;
      end
    end
  endtask

  initial begin
    int cnt, fx, fy, lx, ly, bc, dat;
    int nd;
    int d_idx [6];
    int d_t   [6];
    int t;
    int ord [6];

    reset = 1'b1; req = '0; erase_in = '0; x_base = '0; y_base = '0;
    col_in = '0; shape_in = '0;

    tbl[0] = '{0, 1'b0, 8'd10,  7'd20,  3'b110, 25'h1FFFFFF, 25, 10, 20, 14, 24, 6};
    tbl[1] = '{1, 1'b1, 8'd50,  7'd50,  3'b101, 25'h0000001, 25, 50, 50, 54, 54, 0};
    tbl[2] = '{3, 1'b0, 8'd157, 7'd117, 3'b011, 25'h1FFFFFF, 9, 157, 117, 159, 119, 3};
    tbl[3] = '{3, 1'b0, 8'd60,  7'd60,  3'b111, 25'h0000000, 0, 0, 0, 0, 0, 7};
    tbl[4] = '{0, 1'b0, 8'd254, 7'd126, 3'b010, 25'h1FFFFFF, 9, 0, 0, 2, 2, 2};
    tbl[5] = '{2, 1'b0, 8'd0,   7'd0,   3'b101, 25'h1041041, 5, 0, 0, 4, 4, 5};

    // Reset state
    step(); step();
    chk("rst_plot_en", plot_en, 0);
    chk("rst_x", x, 0);
    chk("rst_y", y, 0);
    chk("rst_colour", colour, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    step();

    // Directed sprite table
    for (int r = 0; r < 6; r++) begin
      x_base = 32'($urandom()); y_base = 28'($urandom()); col_in = 12'($urandom());
      shape_in = 100'({$urandom(), $urandom(), $urandom(), $urandom()});
      erase_in = 4'($urandom());
      x_base[8*tbl[r].idx +: 8]     = tbl[r].xb;
      y_base[7*tbl[r].idx +: 7]     = tbl[r].yb;
      col_in[3*tbl[r].idx +: 3]     = tbl[r].col;
      shape_in[25*tbl[r].idx +: 25] = tbl[r].shp;
      erase_in[tbl[r].idx]          = tbl[r].er;
      run_sprite(tbl[r].idx, cnt, fx, fy, lx, ly, bc, tbl[r].ecol, dat, -1);
      chk("row_plots", cnt, tbl[r].n_plot);
      chk("row_done_cycle", dat, 26);
      chk("row_colour_errs", bc, 0);
      if (tbl[r].n_plot > 0) begin
        chk("row_first_x", fx, tbl[r].fx);
        chk("row_first_y", fy, tbl[r].fy);
        chk("row_last_x", lx, tbl[r].lx);
        chk("row_last_y", ly, tbl[r].ly);
      end
    end

    // Reset at DRAW loc==12 (pointer is 3 here, so 1010 would pick 3 without it)
    req = 4'b0001;
    for (int c = 0; c < 14; c++) step();
    chk("pre_rst_busy", busy, 1);
    reset = 1'b1;
    step();
    chk("midrst_busy", busy, 0);
    chk("midrst_plot_en", plot_en, 0);
    chk("midrst_gnt", gnt, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    req = 4'b1010;
    step(); step();
    chk("midrst_regrant", gnt, 4'b0010);
    for (int c = 0; c < 40 && m_phase != 0; c++) begin
      step();
      if (|done) req = '0;
    end
    req = '0;
    step();

    // Round-robin with req=1011 held
    reset = 1'b1; step(); reset = 1'b0;
    req = 4'b1011; nd = 0; t = 0;
    ord[0] = 0; ord[1] = 1; ord[2] = 3; ord[3] = 0; ord[4] = 1; ord[5] = 3;
    for (int c = 0; c < 200 && nd < 6; c++) begin
      step(); t++;
      if (|done) begin
        for (int b = 0; b < N; b++) if (done[b]) d_idx[nd] = b;
        d_t[nd] = t;
        nd++;
        if (nd == 6) req = '0;
      end
    end
    req = '0;
    step();
    chk("rr_done_count", nd, 6);
    for (int i = 0; i < nd; i++) chk("rr_order", d_idx[i], ord[i]);
    for (int i = 1; i < nd; i++) chk("rr_spacing", d_t[i] - d_t[i-1], 28);

    // Inputs changed and req dropped during DRAW
    x_base[7:0] = 8'd30; y_base[6:0] = 7'd40; col_in[2:0] = 3'd3;
    shape_in[24:0] = 25'h1FFFFFF; erase_in[0] = 1'b0;
    run_sprite(0, cnt, fx, fy, lx, ly, bc, 3, dat, 5);
    chk("chg_plots", cnt, 25);
    chk("chg_first_x", fx, 30);
    chk("chg_last_x", lx, 34);
    chk("chg_last_y", ly, 44);
    chk("chg_colour_errs", bc, 0);
    chk("chg_done_cycle", dat, 26);

    // Random traffic against the model
    for (int it = 0; it < 3000; it++) begin
      reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom());
      erase_in = 4'($urandom());
      x_base   = 32'($urandom());
      y_base   = 28'($urandom());
      col_in   = 12'($urandom());
      shape_in = 100'({$urandom(), $urandom(), $urandom(), $urandom()});
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
